adc_scan_spi: RTL and testbench

//  Parametrised SPI master for ADCx28S022-family 8-channel serial ADCs (8/10/12-bit).

---
 rtl/adc_scan_spi.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_adc_scan_spi.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_spi.sv
// ---------------------------------------------------------------------------
// adc_scan_spi
//   SPI master for ADCx28S022-family 8-channel serial ADCs (8/10/12-bit).
//   Scans the enabled channels of a latched mask once or continuously. Each
//   result is tagged with the channel that produced it. The ADC's one-frame
//   result latency is hidden: the first frame of a scan only primes the
//   converter, and its returned word is dropped.
//
// Parameters
//   CLK_DIV : clk cycles per SCLK half-period (>=1)
//   CS_GAP  : minimum clk cycles CS_N stays high between frames (>=1)
//   DATA_W  : ADC resolution (8, 10 or 12); result = frame bits [11 -: DATA_W]
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   start           : 1-cycle pulse, begins a scan when idle and ch_mask != 0
//   mode            : 0 = single pass, 1 = continuous (latched at start)
//   ch_mask         : enabled channels, bit i = channel i (latched at start)
//   stop            : 1-cycle pulse, finish the current frame and go idle
//   SCLK, DIN, CS_N : ADC serial pins (SCLK idles high, CS_N active low)
//   DOUT            : ADC serial data, sampled on SCLK rising edges
//   busy            : high while a scan is in progress
//   data_valid      : 1-cycle pulse, data/data_ch hold a new result
//   data, data_ch   : conversion result and its channel
//   done            : 1-cycle pulse with the last result of each pass
//   fsm_state       : current FSM state (0 IDLE, 1 SETUP, 2 SHIFT, 3 GAP)
//
// Handshake: start/stop are single-cycle requests with no ready; start is
//   taken only in IDLE, stop only while busy. data_valid/done are
//   single-cycle strobes with no back-pressure.
// ---------------------------------------------------------------------------
module adc_scan_spi #(
   parameter int CLK_DIV = 2,
   parameter int CS_GAP  = 4,
   parameter int DATA_W  = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [7:0]        ch_mask,
   input  logic              stop,
   output logic              SCLK,
   output logic              DIN,
   output logic              CS_N,
   input  logic              DOUT,
   output logic              busy,
   output logic              data_valid,
   output logic [DATA_W-1:0] data,
   output logic [2:0]        data_ch,
   output logic              done,
   output logic [1:0]        fsm_state
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = $clog2(CS_GAP + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   // Frame bit positions (counted from the first bit) holding the result.
   localparam logic [3:0] CAP_FIRST = 4'd4;
   localparam logic [3:0] CAP_LAST  = 4'(3 + DATA_W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_SHIFT = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [3:0]        bit_q, bit_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              sclk_q, sclk_d;
   logic              cs_n_q, cs_n_d;
   logic              din_q, din_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              mode_q, mode_d;
   logic [7:0]        mask_q, mask_d;
   logic [2:0]        addr_q, addr_d;     // channel addressed this frame
   logic [2:0]        res_ch_q, res_ch_d; // channel this frame returns
   logic              res_vld_q, res_vld_d;
   logic              stop_q, stop_d;
   logic              last_q, last_d;     // scan ends after this gap
   logic              dv_q, dv_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [2:0]        data_ch_q, data_ch_d;
   logic              half_end;
   logic              pass_end;

   function automatic logic [2:0] first_ch(input logic [7:0] m);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) r = 3'(i);
      return r;
   endfunction

   function automatic logic [2:0] top_ch(input logic [7:0] m);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++)
         if (m[i]) r = 3'(i);
      return r;
   endfunction

   // Next enabled channel after cur, wrapping; returns cur when it is the
   // only enabled channel (the 8th step wraps back onto cur itself).
   function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] cur);
      logic [2:0] r;
      logic [2:0] idx;
      logic       found;
      r     = cur;
      found = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         idx = cur + 3'(i);
         if (!found && m[idx]) begin
            r     = idx;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   // DIN value for frame bit b (b = 0 is frame bit 15): address on bits 13:11.
   function automatic logic frame_bit(input logic [2:0] a, input logic [3:0] b);
      logic r;
      case (b)
         4'd2:    r = a[2];
         4'd3:    r = a[1];
         4'd4:    r = a[0];
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   assign half_end = (div_q == DIV_LAST);
   assign pass_end = res_vld_q && (res_ch_q == top_ch(mask_q));

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      gap_d     = gap_q;
      sclk_d    = sclk_q;
      cs_n_d    = cs_n_q;
      din_d     = din_q;
      shift_d   = shift_q;
      mode_d    = mode_q;
      mask_d    = mask_q;
      addr_d    = addr_q;
      res_ch_d  = res_ch_q;
      res_vld_d = res_vld_q;
      stop_d    = stop_q;
      last_d    = last_q;
      dv_d      = 1'b0;
      done_d    = 1'b0;
      data_d    = data_q;
      data_ch_d = data_ch_q;

      case (state_q)
         S_IDLE: begin
            if (gap_q != '0) gap_d = gap_q - GAP_ONE;
            if (start && (ch_mask != 8'd0)) begin
               mode_d    = mode;
               mask_d    = ch_mask;
               addr_d    = first_ch(ch_mask);
               res_vld_d = 1'b0;
               stop_d    = 1'b0;
               last_d    = 1'b0;
               div_d     = '0;
               // A restart right after a scan still honours the CS_N gap.
               if (gap_q <= GAP_ONE) begin
                  state_d = S_SETUP;
                  cs_n_d  = 1'b0;
                  sclk_d  = 1'b1;
               end else begin
                  state_d = S_GAP;
               end
            end
         end

         S_SETUP: begin
            stop_d = stop_q | stop;
            if (half_end) begin
               state_d = S_SHIFT;
               div_d   = '0;
               bit_d   = 4'd0;
               sclk_d  = 1'b0;
               din_d   = frame_bit(addr_q, 4'd0);
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         S_SHIFT: begin
            stop_d = stop_q | stop;
            if (!half_end) begin
               div_d = div_q + DIV_W'(1);
            end else begin
               div_d = '0;
               if (!sclk_q) begin
                  // Rising SCLK edge: keep only the result bits of the frame.
                  sclk_d = 1'b1;
                  if (bit_q >= CAP_FIRST && bit_q <= CAP_LAST)
                     shift_d = {shift_q[DATA_W-2:0], DOUT};
               end else if (bit_q == 4'd15) begin
                  // End of frame: release CS_N and publish the previous
                  // frame's channel, if this frame carried a real result.
                  state_d   = S_GAP;
                  cs_n_d    = 1'b1;
                  din_d     = 1'b0;
                  gap_d     = GAP_LOAD;
                  dv_d      = res_vld_q;
                  done_d    = pass_end;
                  last_d    = pass_end && !mode_q;
                  if (res_vld_q) begin
                     data_d    = shift_q;
                     data_ch_d = res_ch_q;
                  end
                  res_ch_d  = addr_q;
                  res_vld_d = 1'b1;
                  addr_d    = next_ch(mask_q, addr_q);
               end else begin
                  sclk_d = 1'b0;
                  bit_d  = bit_q + 4'd1;
                  din_d  = frame_bit(addr_q, bit_q + 4'd1);
               end
            end
         end

         S_GAP: begin
            if (gap_q != '0) gap_d = gap_q - GAP_ONE;
            if (last_q || stop_q || stop) begin
               state_d = S_IDLE;
               stop_d  = 1'b0;
               last_d  = 1'b0;
            end else if (gap_q <= GAP_ONE) begin
               state_d = S_SETUP;
               cs_n_d  = 1'b0;
               sclk_d  = 1'b1;
               div_d   = '0;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         bit_q     <= 4'd0;
         gap_q     <= '0;
         sclk_q    <= 1'b1;
         cs_n_q    <= 1'b1;
         din_q     <= 1'b0;
         shift_q   <= '0;
         mode_q    <= 1'b0;
         mask_q    <= 8'd0;
         addr_q    <= 3'd0;
         res_ch_q  <= 3'd0;
         res_vld_q <= 1'b0;
         stop_q    <= 1'b0;
         last_q    <= 1'b0;
         dv_q      <= 1'b0;
         done_q    <= 1'b0;
         data_q    <= '0;
         data_ch_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         gap_q     <= gap_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         din_q     <= din_d;
         shift_q   <= shift_d;
         mode_q    <= mode_d;
         mask_q    <= mask_d;
         addr_q    <= addr_d;
         res_ch_q  <= res_ch_d;
         res_vld_q <= res_vld_d;
         stop_q    <= stop_d;
         last_q    <= last_d;
         dv_q      <= dv_d;
         done_q    <= done_d;
         data_q    <= data_d;
         data_ch_q <= data_ch_d;
      end
   end

   assign SCLK       = sclk_q;
   assign DIN        = din_q;
   assign CS_N       = cs_n_q;
   assign busy       = (state_q != S_IDLE);
   assign data_valid = dv_q;
   assign data       = data_q;
   assign data_ch    = data_ch_q;
   assign done       = done_q;
   assign fsm_state  = state_q;

endmodule

// File: tb/tb_adc_scan_spi.sv
module tb_adc_scan_spi;

   localparam int CLK_DIV = 2;
   localparam int CS_GAP  = 4;
   localparam int SPAN    = CLK_DIV + 32 * CLK_DIV;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic        stop = 1'b0;
   logic [7:0]  ch_mask = 8'd0;
   logic        dout = 1'b0;

   logic        sclk, din, cs_n, busy, dv, done;
   logic [11:0] data;
   logic [2:0]  data_ch;
   logic [1:0]  st;
   logic        sclk8, din8, cs_n8, busy8, dv8, done8;
   logic [7:0]  data8;
   logic [2:0]  data_ch8;
   logic [1:0]  st8;

   always #5 clk = ~clk;

   adc_scan_spi #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .DATA_W(12)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .ch_mask(ch_mask),
      .stop(stop), .SCLK(sclk), .DIN(din), .CS_N(cs_n), .DOUT(dout),
      .busy(busy), .data_valid(dv), .data(data), .data_ch(data_ch),
      .done(done), .fsm_state(st));

   // Same pin timing as dut; shares DOUT to check the 8-bit result slice.
   adc_scan_spi #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .DATA_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .ch_mask(ch_mask),
      .stop(stop), .SCLK(sclk8), .DIN(din8), .CS_N(cs_n8), .DOUT(dout),
      .busy(busy8), .data_valid(dv8), .data(data8), .data_ch(data_ch8),
      .done(done8), .fsm_state(st8));

   // ---------------- ADC model ----------------
   logic [11:0] m_base = 12'd0;
   logic        m_add = 1'b0;
   logic [2:0]  m_prev = 3'd0;
   logic [15:0] m_word = 16'd0;
   logic [15:0] m_rx = 16'd0;
   int          m_idx = 0;
   int          addr_q[$];
   int          din_bad = 0;

   always @(negedge cs_n) begin
      m_word = {4'b0000, m_base + (m_add ? 12'(m_prev) : 12'd0)};
      m_idx  = 16;
      m_rx   = 16'd0;
      dout   = 1'b0;
   end
   always @(negedge sclk) if (!cs_n && m_idx > 0) begin
      m_idx = m_idx - 1;
      dout  = m_word[m_idx];
   end
   always @(posedge sclk) if (!cs_n) m_rx = {m_rx[14:0], din};
   always @(posedge cs_n) begin
      addr_q.push_back(int'(m_rx[13:11]));
      if ((m_rx & 16'hC7FF) != 16'd0) din_bad++;
      m_prev = m_rx[13:11];
   end

   // ---------------- monitor / scoreboard ----------------
   logic [14:0] exp_q[$];
   logic [14:0] got_q[$];
   logic [7:0]  got8_q[$];
   int          span_q[$];
   int          cyc = 0, low_cnt = 0, done_cnt = 0, done_no_dv = 0;
   int          done_cyc = -10, busy_fall_cyc = -20;
   logic        busy_prev = 1'b0;
   int          total = 0, bad = 0;

   always @(negedge clk) begin
      cyc++;
      if (dv) begin
         got_q.push_back({data_ch, data});
         got8_q.push_back(data8);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         if (!dv) done_no_dv++;
      end
      if (busy_prev && !busy) busy_fall_cyc = cyc;
      busy_prev = busy;
      if (!cs_n) low_cnt++;
      else if (low_cnt != 0) begin
         span_q.push_back(low_cnt);
         low_cnt = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      @(negedge clk);
      #1;
      got_q.delete(); got8_q.delete(); span_q.delete(); addr_q.delete(); exp_q.delete();
      done_cnt = 0; done_no_dv = 0; din_bad = 0; done_cyc = -10; busy_fall_cyc = -20;
      low_cnt = 0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input logic m, input logic [7:0] mk, input logic with_stop);
      @(negedge clk);
      mode = m; ch_mask = mk; start = 1'b1; stop = with_stop;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(busy), 32'd0);
      @(negedge clk);
   endtask

   task automatic check_results();
      int n;
      logic [14:0] r, e;
      logic [7:0]  r8;
      check("result_count", got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         r  = got_q.pop_front();
         r8 = got8_q.pop_front();
         e  = exp_q.pop_front();
         check("res_ch", 32'(r[14:12]), 32'(e[14:12]));
         check("res_data", 32'(r[11:0]), 32'(e[11:0]));
         check("res_data8", 32'(r8), 32'(e[11:4]));
      end
   endtask

   task automatic check_spans();
      foreach (span_q[i]) check("cs_low_span", span_q[i], SPAN);
      check("din_idle_bits", din_bad, 0);
   endtask

   // Single pass over mask; expectations come from the enabled channel list.
   task automatic run_single(input logic [7:0] mk, input logic [11:0] base, input logic add,
                             input int frames, input logic [2:0] last_ch);
      int chs[$];
      clear_mon();
      m_base = base; m_add = add;
      for (int c = 0; c < 8; c++) if (mk[c]) begin
         chs.push_back(c);
         exp_q.push_back({3'(c), base + (add ? 12'(c) : 12'd0)});
      end
      pulse_start(1'b0, mk, 1'b0);
      check("busy_rise", 32'(busy), 32'd1);
      wait_idle(3000);
      check("frame_count", addr_q.size(), frames);
      if (addr_q.size() == chs.size() + 1) begin
         for (int i = 0; i < chs.size(); i++) check("addr", addr_q[i], chs[i]);
         check("addr_reprime", addr_q[chs.size()], chs[0]);
      end
      if (got_q.size() != 0) check("last_ch", 32'(got_q[got_q.size()-1][14:12]), 32'(last_ch));
      check("done_count", done_cnt, 1);
      check("done_with_dv", done_no_dv, 0);
      check("busy_fall_after_done", busy_fall_cyc, done_cyc + 1);
      check_results();
      check_spans();
   endtask

   typedef struct {
      logic [7:0]  mask;
      logic [11:0] base;
      logic        add;
      int          frames;
      logic [2:0]  last_ch;
   } vec_t;
   vec_t vt[6];

   initial begin
      int flag;
      vt[0] = '{8'h08, 12'hABC, 1'b0, 2, 3'd3};
      vt[1] = '{8'h85, 12'h100, 1'b1, 4, 3'd7};
      vt[2] = '{8'h01, 12'h5A5, 1'b1, 2, 3'd0};
      vt[3] = '{8'hFF, 12'h300, 1'b1, 9, 3'd7};
      vt[4] = '{8'h80, 12'hFF0, 1'b0, 2, 3'd7};
      vt[5] = '{8'h42, 12'h7E0, 1'b1, 3, 3'd6};

      // Reset and idle behaviour.
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      repeat (50) @(negedge clk);
      check("rst_sclk", 32'(sclk), 32'd1);
      check("rst_cs_n", 32'(cs_n), 32'd1);
      check("rst_din", 32'(din), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_data_ch", 32'(data_ch), 32'd0);
      check("rst_state", 32'(st), 32'd0);
      check("rst_no_dv", got_q.size(), 0);
      check("rst_no_done", done_cnt, 0);
      check("rst_no_frame", span_q.size(), 0);

      // Single passes from the table.
      for (int i = 0; i < 6; i++)
         run_single(vt[i].mask, vt[i].base, vt[i].add, vt[i].frames, vt[i].last_ch);

      // Continuous mask 0x03, stop right after the second done.
      clear_mon();
      m_base = 12'h200; m_add = 1'b1;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back({3'd0, 12'h200});
         exp_q.push_back({3'd1, 12'h201});
      end
      pulse_start(1'b1, 8'h03, 1'b0);
      flag = 0;
      while (done_cnt < 2 && flag < 3000) begin
         @(negedge clk);
         flag++;
      end
      check("cont_done_timeout", 32'(done_cnt >= 2), 32'd1);
      pulse_stop();
      wait_idle(300);
      check("cont_done_count", done_cnt, 2);
      check("cont_dv_range", 32'(got_q.size() >= 4 && got_q.size() <= 5), 32'd1);
      check("cont_frames", addr_q.size(), got_q.size() + 1);
      foreach (addr_q[i]) check("cont_addr", addr_q[i], i % 2);
      if (got_q.size() == 5) check("cont_extra_ch", 32'(got_q[4][14:12]), 32'd0);
      while (got_q.size() > 4) begin
         void'(got_q.pop_back());
         void'(got8_q.pop_back());
      end
      check_results();
      check_spans();

      // Stop during the priming frame: frame completes, no result, no done.
      clear_mon();
      pulse_start(1'b1, 8'h05, 1'b0);
      repeat (20) @(negedge clk);
      pulse_stop();
      wait_idle(300);
      check("stop0_frames", addr_q.size(), 1);
      check("stop0_dv", got_q.size(), 0);
      check("stop0_done", done_cnt, 0);
      check_spans();

      // Start with an empty mask does nothing.
      clear_mon();
      pulse_start(1'b0, 8'h00, 1'b0);
      flag = 0;
      repeat (100) begin
         @(negedge clk);
         if (busy || !cs_n) flag = 1;
      end
      check("mask0_idle", flag, 0);
      check("mask0_frames", addr_q.size(), 0);

      // Start and stop together in IDLE: start wins, full pass.
      clear_mon();
      m_base = 12'h011; m_add = 1'b1;
      pulse_start(1'b0, 8'h02, 1'b1);
      wait_idle(1000);
      check("ss_frames", addr_q.size(), 2);
      check("ss_done", done_cnt, 1);
      exp_q.push_back({3'd1, 12'h012});
      check_results();

      // Start and input changes while busy are ignored.
      clear_mon();
      m_base = 12'h400; m_add = 1'b1;
      pulse_start(1'b0, 8'h10, 1'b0);
      repeat (30) @(negedge clk);
      pulse_start(1'b1, 8'hFF, 1'b0);
      wait_idle(1000);
      check("busy_start_frames", addr_q.size(), 2);
      foreach (addr_q[i]) check("busy_start_addr", addr_q[i], 4);
      check("busy_start_done", done_cnt, 1);
      exp_q.push_back({3'd4, 12'h404});
      check_results();

      // Asynchronous reset in the middle of a frame.
      clear_mon();
      pulse_start(1'b1, 8'h06, 1'b0);
      repeat (20) @(negedge clk);
      check("pre_rst_shift", 32'(st), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("async_cs_n", 32'(cs_n), 32'd1);
      check("async_sclk", 32'(sclk), 32'd1);
      check("async_busy", 32'(busy), 32'd0);
      check("async_dv", 32'(dv), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("async_no_result", got_q.size(), 0);
      run_single(8'h06, 12'h040, 1'b1, 3, 3'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard bound on run time.
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
